icache_direct: RTL

- Direct-mapped, one-word-per-frame instruction cache between the single-cycle datapath fetch port and the memory controller.
- Serves datapath instruction reads with a same-cycle hit. On a miss it runs a blocking refill from the memory controller, then serves the hit.
- Read-only: no write path, no dirty state.

---
 rtl/icache_direct_if.sv | 21 ++
 rtl/icache_direct.sv | 94 +++++++++
 2 files changed

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and memory-side signals of the direct-mapped instruction cache
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-frame instruction cache with blocking refill (optional ICACHE_PERF_CNT_EN counters)
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  cif
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state;
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags  [SETS];
    logic [31:0]     words [SETS];
    logic [29:0]     miss_word;

    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] atag;
    logic            hit;
    logic            miss;
    logic            fill;
    logic            unused_offset;

    // Byte offset bits never select anything: fetches are whole words.
    assign unused_offset = &{1'b0, cif.imemaddr[1:0]};

    assign idx      = cif.imemaddr[2+IDXW-1:2];
    assign atag     = cif.imemaddr[31:2+IDXW];
    assign fill_idx = miss_word[IDXW-1:0];

    assign hit  = (state == IDLE) && cif.imemREN && valid[idx] && (tags[idx] == atag);
    assign miss = (state == IDLE) && cif.imemREN && !hit;
    assign fill = (state == FETCH) && !cif.iwait;

    assign cif.ihit     = hit;
    assign cif.imemload = hit ? words[idx] : 32'd0;
    assign cif.iREN     = (state == FETCH);
    assign cif.iaddr    = (state == FETCH) ? {miss_word, 2'b00} : 32'd0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_word <= '0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_word <= cif.imemaddr[31:2];
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // The refill always lands at the latched address, whatever the PC does meanwhile.
                    if (!cif.iwait) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fill_idx]  <= miss_word[29:IDXW];
            words[fill_idx] <= cif.iload;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            if (miss)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
